// File: rtl/sa_cache_miss_ctrl.sv
// sa_cache_miss_ctrl: dirty-victim write-back then line fill for sa_cache, with stats and timeout
module sa_cache_miss_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int LINE_W   = 32,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cache_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              i_evict,
  input  logic [ADDR_W-1:0] i_evict_addr,
  input  logic [LINE_W-1:0] i_evict_data,
  output logic [LINE_W-1:0] o_memory_line,
  output logic              o_memory_response,
  output logic              o_busy,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [LINE_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [LINE_W-1:0] i_mem_rdata,
  output logic              o_timeout_err,
  output logic [CNT_W-1:0]  o_miss_cnt,
  output logic [CNT_W-1:0]  o_wb_cnt
);
  typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [31:0] WAIT_LIM = 32'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d, ev_addr_q, ev_addr_d;
  logic [LINE_W-1:0] ev_data_q, ev_data_d, line_q, line_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;
  logic [31:0] wait_q, wait_d;
  logic err_q, err_d, timed_out, unused_ok;
  assign unused_ok = ^{i_miss_addr[OFFSET_W-1:0], i_evict_addr[OFFSET_W-1:0]};
  assign timed_out = (TIMEOUT != 0) && (wait_q == WAIT_LIM) && !i_mem_ack;
  assign o_busy            = state_q != IDLE;
  assign o_mem_req         = state_q == WB || state_q == FILL;
  assign o_mem_we          = state_q == WB;
  assign o_mem_addr        = state_q == WB ? ev_addr_q : state_q == FILL ? fill_addr_q : '0;
  assign o_mem_wdata       = o_mem_we ? ev_data_q : '0;
  assign o_memory_response = state_q == RESP;
  assign o_memory_line     = line_q;
  assign o_timeout_err     = err_q;
  assign o_miss_cnt        = miss_cnt_q;
  assign o_wb_cnt          = wb_cnt_q;
  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    ev_addr_d   = ev_addr_q;
    ev_data_d   = ev_data_q;
    line_d      = line_q;
    miss_cnt_d  = miss_cnt_q;
    wb_cnt_d    = wb_cnt_q;
    err_d       = err_q;
    wait_d      = o_mem_req ? wait_q + 32'd1 : '0;
    case (state_q)
      IDLE: if (i_cache_miss) begin
        fill_addr_d = {i_miss_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        ev_addr_d   = {i_evict_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        ev_data_d   = i_evict_data;
        miss_cnt_d  = &miss_cnt_q ? miss_cnt_q : miss_cnt_q + CNT_ONE;
        wb_cnt_d    = (i_evict && !(&wb_cnt_q)) ? wb_cnt_q + CNT_ONE : wb_cnt_q;
        state_d     = i_evict ? WB : FILL;
      end
      // a timed-out write-back is dropped and the fill still goes ahead
      WB: if (i_mem_ack || timed_out) begin
        state_d = FILL;
        wait_d  = '0;
        err_d   = err_q | timed_out;
      end
      FILL: if (i_mem_ack || timed_out) begin
        state_d = RESP;
        line_d  = i_mem_ack ? i_mem_rdata : '0;
        err_d   = err_q | timed_out;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      fill_addr_q <= '0;
      ev_addr_q   <= '0;
      ev_data_q   <= '0;
      line_q      <= '0;
      miss_cnt_q  <= '0;
      wb_cnt_q    <= '0;
      wait_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      ev_addr_q   <= ev_addr_d;
      ev_data_q   <= ev_data_d;
      line_q      <= line_d;
      miss_cnt_q  <= miss_cnt_d;
      wb_cnt_q    <= wb_cnt_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_sa_cache_miss_ctrl.sv
// tb_sa_cache_miss_ctrl: directed vector table plus timeout, async reset and saturation sequences
module tb_sa_cache_miss_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic miss = 1'b0, ev = 1'b0, ack = 1'b0;
  logic [31:0] maddr = '0, eaddr = '0, edata = '0, rdata = '0;
  logic [31:0] line, mem_addr, wdata;
  logic resp, busy, req, we, err;
  logic [7:0] mc, wc;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  sa_cache_miss_ctrl #(.CNT_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .i_cache_miss(miss), .i_miss_addr(maddr), .i_evict(ev),
    .i_evict_addr(eaddr), .i_evict_data(edata), .o_memory_line(line),
    .o_memory_response(resp), .o_busy(busy), .o_mem_req(req), .o_mem_we(we),
    .o_mem_addr(mem_addr), .o_mem_wdata(wdata), .i_mem_ack(ack), .i_mem_rdata(rdata),
    .o_timeout_err(err), .o_miss_cnt(mc), .o_wb_cnt(wc)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  typedef struct {
    logic [31:0] miss, addr, ev, eaddr, edata, ack, rdata;
    logic [31:0] busy, req, we, resp, maddr, wdata, line, mc, wc;
  } vec_t;
  vec_t v[19];
  initial begin
    v[0]  = '{1, 32'h1234, 0, 0, 0, 0, 0,                          1, 1, 0, 0, 32'h1200, 0, 0, 1, 0};
    v[1]  = '{1, 32'h1234, 0, 0, 0, 0, 0,                          1, 1, 0, 0, 32'h1200, 0, 0, 1, 0};
    v[2]  = v[1];
    v[3]  = v[1];
    v[4]  = '{1, 32'h1234, 0, 0, 0, 1, 32'hDEADBEEF,               1, 0, 0, 1, 0, 0, 32'hDEADBEEF, 1, 0};
    v[5]  = '{0, 0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, 0};
    v[6]  = '{1, 32'h00800A10, 1, 32'h00400A3C, 32'hCAFEF00D, 1, 0, 1, 1, 1, 0, 32'h00400A00, 32'hCAFEF00D, 32'hDEADBEEF, 2, 1};
    v[7]  = '{1, 32'h00800A10, 1, 32'hFFFFFFFF, 32'h11111111, 1, 0, 1, 1, 0, 0, 32'h00800A00, 0, 32'hDEADBEEF, 2, 1};
    v[8]  = '{1, 32'h00800A10, 1, 32'hFFFFFFFF, 32'h11111111, 1, 32'h12345678, 1, 0, 0, 1, 0, 0, 32'h12345678, 2, 1};
    v[9]  = '{0, 0, 0, 0, 0, 1, 0,                                 0, 0, 0, 0, 0, 0, 32'h12345678, 2, 1};
    v[10] = '{0, 0, 0, 0, 0, 1, 32'h99999999,                      0, 0, 0, 0, 0, 0, 32'h12345678, 2, 1};
    v[11] = '{1, 32'h40, 0, 0, 0, 0, 0,                            1, 1, 0, 0, 32'h40, 0, 32'h12345678, 3, 1};
    v[12] = '{0, 32'h40, 0, 0, 0, 0, 0,                            1, 1, 0, 0, 32'h40, 0, 32'h12345678, 3, 1};
    v[13] = '{1, 32'h40, 1, 32'h500, 32'h77, 0, 0,                 1, 1, 0, 0, 32'h40, 0, 32'h12345678, 3, 1};
    v[14] = '{1, 32'h40, 0, 0, 0, 1, 32'hA5A5A5A5,                 1, 0, 0, 1, 0, 0, 32'hA5A5A5A5, 3, 1};
    v[15] = '{1, 32'hC0, 0, 0, 0, 0, 0,                            0, 0, 0, 0, 0, 0, 32'hA5A5A5A5, 3, 1};
    v[16] = '{1, 32'hC0, 0, 0, 0, 0, 0,                            1, 1, 0, 0, 32'hC0, 0, 32'hA5A5A5A5, 4, 1};
    v[17] = '{1, 32'hC0, 0, 0, 0, 1, 32'h0BADF00D,                 1, 0, 0, 1, 0, 0, 32'h0BADF00D, 4, 1};
    v[18] = '{0, 0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0, 0, 0, 32'h0BADF00D, 4, 1};
    #2;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_req", {31'b0, req}, 0);
    chk("rst_line", line, 0);
    chk("rst_cnt", {16'b0, mc, wc}, 0);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 19; i++) begin
      miss = v[i].miss[0]; maddr = v[i].addr; ev = v[i].ev[0];
      eaddr = v[i].eaddr; edata = v[i].edata; ack = v[i].ack[0]; rdata = v[i].rdata;
      @(posedge clk); #1;
      chk($sformatf("v%0d_busy", i), {31'b0, busy}, v[i].busy);
      chk($sformatf("v%0d_req", i), {31'b0, req}, v[i].req);
      chk($sformatf("v%0d_we", i), {31'b0, we}, v[i].we);
      chk($sformatf("v%0d_resp", i), {31'b0, resp}, v[i].resp);
      chk($sformatf("v%0d_line", i), line, v[i].line);
      chk($sformatf("v%0d_mcnt", i), {24'b0, mc}, v[i].mc);
      chk($sformatf("v%0d_wcnt", i), {24'b0, wc}, v[i].wc);
      chk($sformatf("v%0d_err", i), {31'b0, err}, 0);
      if (v[i].req[0]) chk($sformatf("v%0d_addr", i), mem_addr, v[i].maddr);
      if (v[i].we[0]) chk($sformatf("v%0d_wdata", i), wdata, v[i].wdata);
    end
    // fill never acknowledged: 16 request cycles then forced empty response
    miss = 1'b1; maddr = 32'h0000_0300; ev = 1'b0; ack = 1'b0;
    @(posedge clk); #1;
    miss = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("to_still_req", {30'b0, req, resp}, 32'h2);
    chk("to_err_early", {31'b0, err}, 0);
    @(posedge clk); #1;
    chk("to_resp", {31'b0, resp}, 1);
    chk("to_err", {31'b0, err}, 1);
    chk("to_line", line, 0);
    chk("to_mcnt", {24'b0, mc}, 5);
    @(posedge clk); #1;
    chk("to_idle", {31'b0, busy}, 0);
    miss = 1'b1; maddr = 32'h0000_0400; ack = 1'b1; rdata = 32'h13579BDF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("post_to_resp", {31'b0, resp}, 1);
    chk("post_to_line", line, 32'h13579BDF);
    chk("post_to_err", {31'b0, err}, 1);
    miss = 1'b0; ack = 1'b0;
    @(posedge clk); #1;
    // asynchronous reset dropped between edges while filling
    miss = 1'b1; maddr = 32'h0000_0500;
    @(posedge clk); #1;
    chk("pre_rst_req", {31'b0, req}, 1);
    miss = 1'b0;
    @(negedge clk); #2 rst = 1'b0;
    #1;
    chk("arst_ctrl", {27'b0, busy, req, we, resp, err}, 0);
    chk("arst_line", line, 0);
    chk("arst_cnt", {16'b0, mc, wc}, 0);
    @(negedge clk) rst = 1'b1;
    miss = 1'b1; maddr = 32'h0000_067F; ack = 1'b1; rdata = 32'h2468ACE0;
    @(posedge clk); #1;
    chk("rel_addr", mem_addr, 32'h640);
    chk("rel_mcnt", {24'b0, mc}, 1);
    @(posedge clk); #1;
    chk("rel_resp", {31'b0, resp}, 1);
    chk("rel_line", line, 32'h2468ACE0);
    // back-to-back dirty misses saturate both counters
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    miss = 1'b1; ev = 1'b1; ack = 1'b1;
    repeat (1200) @(posedge clk);
    #1;
    chk("sat_mcnt", {24'b0, mc}, 32'hFF);
    chk("sat_wcnt", {24'b0, wc}, 32'hFF);
    repeat (40) @(posedge clk);
    #1;
    chk("sat_hold", {16'b0, mc, wc}, 32'hFFFF);
    miss = 1'b0; ev = 1'b0; ack = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/sa_cache_miss_ctrl.md
Name: sa_cache_miss_ctrl

Overview:
Memory-side miss/refill controller sitting directly downstream of sa_cache. It accepts a miss request and an optional dirty-victim eviction from the cache. It performs the write-back first, then the line fill, over a req/ack memory handshake. It returns the fetched line to the cache on i_memory_line/i_memory_response, and keeps saturating miss and write-back counters plus a sticky timeout error.

Parameters:
ADDR_W, 32, byte address width; the address is {tag[17:0], index[7:0], offset[5:0]}.
OFFSET_W, 6, offset bits cleared to form line-aligned addresses.
LINE_W, 32, width of a cache line transfer.
CNT_W, 16, width of the statistics counters.
TIMEOUT, 64, cycles to wait for i_mem_ack before aborting; 0 disables the timeout.

Ports:
clk  in  1  clock, all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
i_cache_miss  in  1  the cache reports a miss; level, held by the cache until o_memory_response.
i_miss_addr  in  ADDR_W  address of the missing access.
i_evict  in  1  the victim line is dirty and must be written back; qualified by i_cache_miss.
i_evict_addr  in  ADDR_W  victim address.
i_evict_data  in  LINE_W  victim data.
o_memory_line  out  LINE_W  fetched line, driven to the cache's i_memory_line.
o_memory_response  out  1  one-cycle pulse, driven to the cache's i_memory_response.
o_busy  out  1  a transaction is in progress.
o_mem_req  out  1  memory request.
o_mem_we  out  1  1 = write-back, 0 = fill read.
o_mem_addr  out  ADDR_W  line-aligned memory address.
o_mem_wdata  out  LINE_W  write-back data.
i_mem_ack  in  1  memory completes the current request in this cycle.
i_mem_rdata  in  LINE_W  read data, valid when i_mem_ack=1 and o_mem_we=0.
o_timeout_err  out  1  sticky timeout flag.
o_miss_cnt  out  CNT_W  accepted misses.
o_wb_cnt  out  CNT_W  accepted write-backs.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; every output and counter goes to 0, including o_memory_line.
  - Takes effect immediately, even mid-transaction; any outstanding memory request is abandoned.
- FSM states: IDLE, WB, FILL, RESP. All outputs are registered or decoded from state and captured registers.
- IDLE:
  - o_busy=0, o_mem_req=0.
  - i_cache_miss=1 at an edge: capture {i_miss_addr[ADDR_W-1:OFFSET_W], OFFSET_W'b0} as the fill address, and capture i_evict, i_evict_addr (aligned the same way) and i_evict_data.
  - o_miss_cnt increments; o_wb_cnt increments if i_evict=1. Both counters saturate at all-ones.
  - Next state is WB if i_evict=1, else FILL.
- WB:
  - o_busy=1, o_mem_req=1, o_mem_we=1, o_mem_addr=aligned victim address, o_mem_wdata=victim data.
  - i_mem_ack=1 at an edge: next state FILL.
- FILL:
  - o_busy=1, o_mem_req=1, o_mem_we=0, o_mem_addr=aligned miss address.
  - i_mem_ack=1 at an edge: o_memory_line<=i_mem_rdata, next state RESP.
- RESP:
  - o_memory_response=1 for exactly one cycle, o_busy=1, o_mem_req=0; next state IDLE.
  - o_memory_line holds its value until the next fill completes.
- Memory handshake:
  - o_mem_req stays high across the WB-to-FILL transition; each sampled ack completes exactly one request.
  - o_mem_we/o_mem_addr/o_mem_wdata change only on the edge where the ack is sampled.
  - An ack is legal in the same cycle req rises. i_mem_ack in IDLE or RESP is ignored.
- Latency:
  - With an immediate ack and no eviction, a miss sampled at edge N yields o_memory_response high in cycle N+2.
  - Each write-back adds one cycle plus its memory wait.
- i_cache_miss is ignored in WB/FILL/RESP. The cache drops the miss in the response cycle; a miss still high in the IDLE cycle after RESP is accepted as a new miss.
- Changes to i_evict* or i_miss_addr after capture have no effect.
- Timeout (TIMEOUT>0):
  - A wait counter clears on entry to WB and to FILL, and increments each cycle req=1 and ack=0.
  - When it reaches TIMEOUT: o_timeout_err<=1 (sticky, cleared only by reset).
  - In WB, proceed to FILL (the write-back is dropped).
  - In FILL, set o_memory_line<=0 and go to RESP, so the cache always receives a response.

Test Plan:
- Clean miss: i_miss_addr=0x0000_1234, i_evict=0, ack after 3 wait cycles with rdata 0xDEADBEEF -> one read at 0x0000_1200 (we=0), response pulse 1 cycle after ack, o_memory_line=0xDEADBEEF, miss_cnt=1, wb_cnt=0.
- Dirty eviction: evict_addr=0x0040_0A3C, evict_data=0xCAFEF00D, miss_addr=0x0080_0A10, immediate acks -> write 0x0040_0A00/0xCAFEF00D, then read 0x0080_0A00 with req continuously high, response in cycle N+3, wb_cnt=1.
- Miss held or toggled during FILL, and a spurious ack in IDLE -> no extra memory request, miss_cnt increments once only.
- TIMEOUT=16, no ack in FILL -> after 16 req cycles o_timeout_err=1, response pulse with o_memory_line=0; the flag stays set through a following successful miss.
- rst driven low mid-FILL, between clock edges -> all outputs 0 immediately, counters 0, state IDLE; a new miss after release is handled normally.
- 70000 back-to-back misses with CNT_W=16 -> o_miss_cnt saturates at 0xFFFF and does not wrap.
